// File: rtl/score_display.sv
// score_display
//   Draws the 8-bit game score as up to three decimal digits (3x5 font,
//   scaled x4) in the top strip of the VGA frame. The score is converted
//   from binary to BCD once per frame, during vertical blanking, by a
//   sequential double-dabble converter. The displayed digits therefore
//   never change partway through a frame.
//
// Parameters
//   X0          left edge of the hundreds digit (pixels)
//   Y0          top edge of the digits (pixels)
//   SCORE_COLOR colour of lit glyph pixels
// Ports
//   i_clk       pixel clock (shared with the VGA timing generator)
//   i_rst_n     asynchronous active-low reset
//   i_hpos      current pixel x coordinate
//   i_vpos      current pixel y coordinate
//   i_score     binary score, 0..255
//   o_score_rgb glyph colour, or 3'b000 where nothing is drawn (1-cycle latency)
//   o_digits    displayed BCD value {hundreds, tens, ones}
//   o_busy      high while a conversion is in progress
module score_display #(
  parameter logic [9:0] X0          = 10'd8,
  parameter logic [9:0] Y0          = 10'd6,
  parameter logic [2:0] SCORE_COLOR = 3'b111
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_hpos,
  input  logic [9:0]  i_vpos,
  input  logic [7:0]  i_score,
  output logic [2:0]  o_score_rgb,
  output logic [11:0] o_digits,
  output logic        o_busy
);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t      state, state_next;
  logic [19:0] shift_q, shift_step;
  logic [2:0]  iter_q;
  logic        strobe, last_iter;

  logic [9:0]  rx, ry;
  logic        in_region, blank, pix_on;
  logic [3:0]  cur_digit;
  logic [2:0]  glyph_row, col_shift;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // Glyph rows, top to bottom, MSB = leftmost column.
  function automatic logic [2:0] font_row(input logic [3:0] d, input logic [2:0] r);
    logic [14:0] g;
    case (d)
      4'd0:    g = 15'b111_101_101_101_111;
      4'd1:    g = 15'b010_110_010_010_111;
      4'd2:    g = 15'b111_001_111_100_111;
      4'd3:    g = 15'b111_001_111_001_111;
      4'd4:    g = 15'b101_101_111_001_001;
      4'd5:    g = 15'b111_100_111_001_111;
      4'd6:    g = 15'b111_100_111_101_111;
      4'd7:    g = 15'b111_001_001_001_001;
      4'd8:    g = 15'b111_101_111_101_111;
      4'd9:    g = 15'b111_101_111_001_111;
      default: g = '0;
    endcase
    case (r)
      3'd0:    return g[14:12];
      3'd1:    return g[11:9];
      3'd2:    return g[8:6];
      3'd3:    return g[5:3];
      3'd4:    return g[2:0];
      default: return '0;
    endcase
  endfunction

  assign strobe    = (i_vpos == 10'd480) && (i_hpos == 10'd0);
  assign last_iter = (iter_q == 3'd7);

  // One double-dabble step: correct BCD nibbles, then shift left.
  always_comb begin
    shift_step = {add3(shift_q[19:16]), add3(shift_q[15:12]),
                  add3(shift_q[11:8]), shift_q[7:0]} << 1;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic; strobes while converting are ignored
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (strobe)    state_next = CONVERT;
      CONVERT: if (last_iter) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_busy = (state == CONVERT);
  end

  // Converter datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q  <= '0;
      iter_q   <= '0;
      o_digits <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (strobe) begin
            shift_q <= {12'b0, i_score};
            iter_q  <= '0;
          end
        end
        CONVERT: begin
          shift_q <= shift_step;
          iter_q  <= iter_q + 3'd1;
          if (last_iter) o_digits <= shift_step[19:8];
        end
        default: ;
      endcase
    end
  end

  // Pixel path. Coordinates left of / above the origin wrap to large
  // unsigned values and fall outside the region.
  always_comb begin
    rx        = i_hpos - X0;
    ry        = i_vpos - Y0;
    in_region = (rx < 10'd48) && (ry < 10'd20) && (rx[3:0] < 4'd12);
    case (rx[5:4])
      2'd0: begin
        cur_digit = o_digits[11:8];
        blank     = (o_digits[11:8] == 4'd0);
      end
      2'd1: begin
        cur_digit = o_digits[7:4];
        blank     = (o_digits[11:4] == 8'd0);
      end
      default: begin
        cur_digit = o_digits[3:0];
        blank     = 1'b0;
      end
    endcase
    glyph_row = font_row(cur_digit, ry[4:2]);
    col_shift = glyph_row << rx[3:2];
    pix_on    = in_region && !blank && col_shift[2];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_score_rgb <= '0;
    else          o_score_rgb <= pix_on ? SCORE_COLOR : 3'b000;
  end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int PX0 = 8;
  localparam int PY0 = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos, vpos;
  logic [7:0]  score;
  logic [2:0]  rgb;
  logic [11:0] digits;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int shown    = 0;   // score the model expects on screen

  int font [10][5] = '{
    '{7,5,5,5,7}, '{2,6,2,2,7}, '{7,1,7,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
    '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,1,1,1}, '{7,5,7,5,7}, '{7,5,7,1,7}
  };

  score_display #(.X0(10'd8), .Y0(10'd6), .SCORE_COLOR(3'b111)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_hpos(hpos), .i_vpos(vpos),
    .i_score(score), .o_score_rgb(rgb), .o_digits(digits), .o_busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd(input int s);
    return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
  endfunction

  function automatic logic [2:0] exp_pix(input int x, input int y, input int s);
    int d [3];
    d[0] = s / 100; d[1] = (s / 10) % 10; d[2] = s % 10;
    for (int k = 0; k < 3; k++) begin
      int left;
      left = PX0 + 16 * k;
      if (x >= left && x <= left + 11 && y >= PY0 && y <= PY0 + 19) begin
        if (k == 0 && d[0] == 0) return 3'b000;
        if (k == 1 && d[0] == 0 && d[1] == 0) return 3'b000;
        if (((font[d[k]][(y - PY0) / 4] >> (2 - (x - left) / 4)) & 1) == 1)
          return 3'b111;
        return 3'b000;
      end
    end
    return 3'b000;
  endfunction

  // One frame strobe with score s; checks busy length and the result.
  task automatic frame(input int s, input string tag);
    int hi;
    @(negedge clk);
    score = 8'(s); vpos = 10'd480; hpos = 10'd0;
    @(negedge clk);
    vpos = 10'd481; hpos = 10'd1;
    hi = 0;
    while (busy === 1'b1 && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    shown = s;
    n_checks++;
    if (hi !== 8) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d expected 8", tag, hi);
    end
    n_checks++;
    if (digits !== bcd(s)) begin
      n_fail++;
      $display("FAIL %s digits: got %h expected %h", tag, digits, bcd(s));
    end
  endtask

  // Drive one pixel, check the registered colour one cycle later.
  task automatic pixel(input int x, input int y, input logic [2:0] want, input string tag);
    @(negedge clk);
    hpos = 10'(x); vpos = 10'(y);
    @(negedge clk);
    n_checks++;
    if (rgb !== want) begin
      n_fail++;
      $display("FAIL %s pix(%0d,%0d): got %b expected %b", tag, x, y, rgb, want);
    end
  endtask

  // Pipelined raster scan of a rectangle against the model.
  task automatic scan(input int xa, input int xb, input int ya, input int yb, input string tag);
    int px, py;
    bit have;
    have = 0; px = 0; py = 0;
    for (int y = ya; y <= yb; y++) begin
      for (int x = xa; x <= xb; x++) begin
        @(negedge clk);
        if (have) begin
          n_checks++;
          if (rgb !== exp_pix(px, py, shown)) begin
            n_fail++;
            $display("FAIL %s scan(%0d,%0d): got %b expected %b", tag, px, py, rgb,
                     exp_pix(px, py, shown));
          end
        end
        hpos = 10'(x); vpos = 10'(y); px = x; py = y; have = 1;
      end
    end
    @(negedge clk);
    n_checks++;
    if (rgb !== exp_pix(px, py, shown)) begin
      n_fail++;
      $display("FAIL %s scan(%0d,%0d): got %b expected %b", tag, px, py, rgb,
               exp_pix(px, py, shown));
    end
  endtask

  task automatic test_reset;
    n_checks++;
    if ({rgb, digits, busy} !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state: got rgb=%b digits=%h busy=%b expected 000/000/0", rgb, digits, busy);
    end
    rst_n = 1'b1;
    // Start converting 200, park on a lit pixel of the displayed "0".
    @(negedge clk);
    score = 8'd200; vpos = 10'd480; hpos = 10'd0;
    @(negedge clk);
    hpos = 10'd40; vpos = 10'd6;
    @(negedge clk);
    n_checks++;
    if (rgb !== 3'b111 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got rgb=%b busy=%b expected 111/1", rgb, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rgb, digits, busy} !== 16'h0) begin
      n_fail++;
      $display("FAIL async_reset: got rgb=%b digits=%h busy=%b expected 000/000/0", rgb, digits, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hpos = 10'd100; vpos = 10'd100;
    repeat (12) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || digits !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_no_resume: got busy=%b digits=%h expected 0/000", busy, digits);
    end
    frame(200, "reset_200");
  endtask

  task automatic test_zero;
    frame(0, "zero");
    pixel(44, 14, 3'b000, "zero_hole");
    pixel(40, 14, 3'b111, "zero_lit");
    scan(4, 56, 4, 27, "zero");
  endtask

  task automatic test_max;
    frame(255, "max");
    pixel(8, 6, 3'b111, "max_h0");
    scan(8, 55, 6, 25, "max");
  endtask

  task automatic test_glyph;
    frame(8, "glyph8");
    for (int y = 10; y <= 13; y++) begin
      for (int x = 40; x <= 55; x++) begin
        pixel(x, y, (x <= 43 || (x >= 48 && x <= 51)) ? 3'b111 : 3'b000, "glyph8_row1");
      end
    end
  endtask

  task automatic test_no_tear;
    frame(17, "tear17");
    @(negedge clk);
    vpos = 10'd200; hpos = 10'd0; score = 8'd42;
    repeat (5) @(negedge clk);
    n_checks++;
    if (digits !== 12'h017 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL no_tear: got digits=%h busy=%b expected 017/0", digits, busy);
    end
    scan(8, 55, 6, 25, "tear_still17");
    frame(42, "tear42");
  endtask

  task automatic test_interior_zero;
    frame(105, "interior");
    pixel(24, 6, 3'b111, "interior_tens");
    pixel(28, 14, 3'b000, "interior_tens_hole");
    scan(8, 55, 6, 25, "interior");
  endtask

  // Strobe while busy must be ignored; then random scores and pixels.
  task automatic test_back_to_back;
    int s, s2, x, y;
    s = 137; s2 = 99;
    @(negedge clk);
    score = 8'(s); vpos = 10'd480; hpos = 10'd0;
    @(negedge clk);
    hpos = 10'd1;
    repeat (2) @(negedge clk);
    score = 8'(s2); hpos = 10'd0;
    @(negedge clk);
    hpos = 10'd1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (digits !== bcd(s) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_strobe_ignored: got digits=%h busy=%b expected %h/0", digits, busy, bcd(s));
    end
    shown = s;
    for (int i = 0; i < 12; i++) begin
      s = $urandom_range(0, 255);
      frame(s, "rand");
      for (int j = 0; j < 40; j++) begin
        x = $urandom_range(0, 63);
        y = $urandom_range(0, 31);
        pixel(x, y, exp_pix(x, y, shown), "rand");
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; hpos = '0; vpos = '0; score = '0;
    repeat (3) @(negedge clk);
    test_reset;
    test_zero;
    test_max;
    test_glyph;
    test_no_tear;
    test_interior_zero;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
